// File: rtl/ajuste_ciclo_pwm.sv
// Duty-cycle setpoint stage: debounced up/down buttons drive a saturating 0-100 % duty
// and the matching 19-bit PWM compare value. Optional auto-repeat: define AUTOREPEAT_EN.

module ajuste_ciclo_pwm_canal #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic btn,
    output logic step_req_s
);
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            s1_r;
    logic            s2_r;
    logic            d_r;
    logic            d_prev_r;
    logic [DB_W-1:0] cnt_r;

    // Synchronizer, debounce counter and edge-detect history
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_r     <= 1'b0;
            s2_r     <= 1'b0;
            d_r      <= 1'b0;
            d_prev_r <= 1'b0;
            cnt_r    <= {DB_W{1'b0}};
        end else begin
            s1_r     <= btn;
            s2_r     <= s1_r;
            d_prev_r <= d_r;
            if (s2_r == d_r) begin
                cnt_r <= {DB_W{1'b0}};
            end else if (cnt_r == DB_LAST) begin
                d_r   <= s2_r;
                cnt_r <= {DB_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + DB_W'(1);
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned HOLD_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_CYCLES - 1);

    logic [HOLD_W-1:0] hold_r;

    // Step on the debounced rising edge, plus one extra per full hold interval
    always_comb begin
        step_req_s = 1'b0;
        if (d_r && (!d_prev_r || (hold_r == HOLD_LAST))) begin
            step_req_s = 1'b1;
        end else begin
            step_req_s = 1'b0;
        end
    end

    // Hold timer restarts on every issued step and whenever the button is released
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_r <= {HOLD_W{1'b0}};
        end else if (!d_r || step_req_s) begin
            hold_r <= {HOLD_W{1'b0}};
        end else begin
            hold_r <= hold_r + HOLD_W'(1);
        end
    end
`else
    // One step per debounced press; release edges are ignored
    always_comb begin
        step_req_s = 1'b0;
        if (d_r && !d_prev_r) begin
            step_req_s = 1'b1;
        end else begin
            step_req_s = 1'b0;
        end
    end
`endif

endmodule

module ajuste_ciclo_pwm #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned STEP_PCT        = 10,
    parameter int unsigned DUTY_INIT       = 50,
    parameter int unsigned PERIOD_COUNTS   = 500_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        BTN_UP,
    input  logic        BTN_DN,
    output logic [18:0] PWM,
    output logic [6:0]  DUTY,
    output logic        AT_MAX,
    output logic        AT_MIN
);
    localparam logic [18:0] COUNTS_PER_PCT = 19'(PERIOD_COUNTS / 100);
    localparam logic [6:0]  STEP           = 7'(STEP_PCT);
    localparam logic [6:0]  DUTY_MAX       = 7'd100;
    localparam logic [6:0]  DUTY_RST       = 7'(DUTY_INIT);
    localparam logic [18:0] PWM_RST        = 19'(DUTY_INIT * (PERIOD_COUNTS / 100));

    logic        up_req_s;
    logic        dn_req_s;
    logic [6:0]  duty_r;
    logic [6:0]  duty_next_s;
    logic [18:0] pwm_r;
    logic [18:0] pwm_calc_s;

    ajuste_ciclo_pwm_canal #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_canal_up (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .btn        (BTN_UP),
        .step_req_s (up_req_s)
    );

    ajuste_ciclo_pwm_canal #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_canal_dn (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .btn        (BTN_DN),
        .step_req_s (dn_req_s)
    );

    // Saturating duty update; limits are compared before the add/subtract so nothing wraps
    always_comb begin
        duty_next_s = duty_r;
        case ({up_req_s, dn_req_s})
            2'b10: begin
                if (duty_r >= (DUTY_MAX - STEP)) begin
                    duty_next_s = DUTY_MAX;
                end else begin
                    duty_next_s = duty_r + STEP;
                end
            end
            2'b01: begin
                if (duty_r <= STEP) begin
                    duty_next_s = 7'd0;
                end else begin
                    duty_next_s = duty_r - STEP;
                end
            end
            default: duty_next_s = duty_r;
        endcase
    end

    assign pwm_calc_s = 19'(duty_r) * COUNTS_PER_PCT;

    // Duty register and compare value, the latter trailing duty by one clock
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            duty_r <= DUTY_RST;
            pwm_r  <= PWM_RST;
        end else begin
            duty_r <= duty_next_s;
            pwm_r  <= pwm_calc_s;
        end
    end

    assign DUTY   = duty_r;
    assign PWM    = pwm_r;
    assign AT_MAX = (duty_r == DUTY_MAX);
    assign AT_MIN = (duty_r == 7'd0);

endmodule

// File: tb/tb_ajuste_ciclo_pwm.sv
// Randomized self-checking bench for ajuste_ciclo_pwm against a cycle-level reference
// model built from raw-sample history windows (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20).

module tb_ajuste_ciclo_pwm;
    localparam int DB   = 4;
    localparam int RP   = 20;
    localparam int STEP = 10;
    localparam int PER  = 500_000;
    localparam int HN   = 16;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        BTN_UP;
    logic        BTN_DN;
    logic [18:0] PWM;
    logic [6:0]  DUTY;
    logic        AT_MAX;
    logic        AT_MIN;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit hist [2][HN];
    bit d_m [2];
    bit rose_m [2];
    int last_step [2];
    int duty_m;
    int pwm_m;
    int edge_n;

    ajuste_ciclo_pwm #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RP)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .BTN_UP (BTN_UP),
        .BTN_DN (BTN_DN),
        .PWM    (PWM),
        .DUTY   (DUTY),
        .AT_MAX (AT_MAX),
        .AT_MIN (AT_MIN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < HN; i++) hist[c][i] = 1'b0;
            d_m[c]       = 1'b0;
            rose_m[c]    = 1'b0;
            last_step[c] = 0;
        end
        duty_m = 50;
        pwm_m  = 250_000;
        edge_n = 0;
    endtask

    task automatic model_edge(input bit up, input bit dn);
        bit req [2];
        bit raw [2];
        bit all_diff;
        int new_duty;
        raw[0] = up;
        raw[1] = dn;
        // compare value follows the duty held before this edge
        pwm_m = duty_m * (PER / 100);
        for (int c = 0; c < 2; c++) begin
            req[c] = rose_m[c];
`ifdef AUTOREPEAT_EN
            if (d_m[c] && !rose_m[c] && (edge_n - last_step[c] == RP)) req[c] = 1'b1;
`endif
            if (req[c]) last_step[c] = edge_n;
        end
        new_duty = duty_m;
        if (req[0] && !req[1]) new_duty = (duty_m + STEP > 100) ? 100 : duty_m + STEP;
        if (req[1] && !req[0]) new_duty = (duty_m < STEP) ? 0 : duty_m - STEP;
        duty_m = new_duty;
        // debounced level flips once the last DB synchronized samples all disagree with it
        for (int c = 0; c < 2; c++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) begin
                if (hist[c][1 + j] == d_m[c]) all_diff = 1'b0;
            end
            rose_m[c] = all_diff && !d_m[c];
            if (all_diff) d_m[c] = !d_m[c];
            for (int i = HN - 1; i > 0; i--) hist[c][i] = hist[c][i - 1];
            hist[c][0] = raw[c];
        end
        edge_n++;
    endtask

    task automatic check_outputs();
        chk("duty",   32'(DUTY),   32'(duty_m));
        chk("pwm",    32'(PWM),    32'(pwm_m));
        chk("at_max", 32'(AT_MAX), 32'(duty_m == 100));
        chk("at_min", 32'(AT_MIN), 32'(duty_m == 0));
    endtask

    task automatic cyc(input bit up, input bit dn);
        BTN_UP = up;
        BTN_DN = dn;
        @(posedge CLK);
        model_edge(up, dn);
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic cycles(input bit up, input bit dn, input int n);
        for (int i = 0; i < n; i++) cyc(up, dn);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        model_reset();
        chk("rst_duty", 32'(DUTY), 32'd50);
        chk("rst_pwm",  32'(PWM),  32'd250_000);
        chk("rst_flags", 32'({AT_MAX, AT_MIN}), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic press(input bit up, input bit dn);
        cycles(up, dn, 8);
        cycles(1'b0, 1'b0, 8);
    endtask

    initial begin
        bit up_lvl;
        bit dn_lvl;
        RST_N  = 1'b0;
        BTN_UP = 1'b0;
        BTN_DN = 1'b0;
        model_reset();
        @(negedge CLK);
        do_reset();
        check_outputs();

        // single press: held 10, then released
        cycles(1'b1, 1'b0, 10);
        chk("press_duty", 32'(DUTY), 32'd60);
        chk("press_pwm",  32'(PWM),  32'd300_000);
        cycles(1'b0, 1'b0, 10);
        chk("release_duty", 32'(DUTY), 32'd60);

        // bounce rejection on the down button, then a real press
        @(negedge CLK);
        do_reset();
        for (int k = 0; k < 12; k++) begin
            cycles(1'b0, 1'b1, $urandom_range(1, 3));
            cycles(1'b0, 1'b0, $urandom_range(1, 3));
        end
        chk("bounce_duty", 32'(DUTY), 32'd50);
        cycles(1'b0, 1'b1, 10);
        cycles(1'b0, 1'b0, 2);
        chk("dn_duty", 32'(DUTY), 32'd40);
        chk("dn_pwm",  32'(PWM),  32'd200_000);
        cycles(1'b0, 1'b0, 8);

        // saturation at both ends
        @(negedge CLK);
        do_reset();
        for (int k = 0; k < 6; k++) press(1'b1, 1'b0);
        chk("sat_hi_duty", 32'(DUTY),   32'd100);
        chk("sat_hi_pwm",  32'(PWM),    32'd500_000);
        chk("sat_hi_flag", 32'(AT_MAX), 32'd1);
        for (int k = 0; k < 11; k++) press(1'b0, 1'b1);
        chk("sat_lo_duty", 32'(DUTY),   32'd0);
        chk("sat_lo_pwm",  32'(PWM),    32'd0);
        chk("sat_lo_flag", 32'(AT_MIN), 32'd1);

        // simultaneous press cancels
        press(1'b1, 1'b0);
        cycles(1'b1, 1'b1, 10);
        cycles(1'b0, 1'b0, 10);
        chk("both_duty", 32'(DUTY), 32'd10);

        // long hold: one step without auto-repeat, repeats up to 100 with it
        @(negedge CLK);
        do_reset();
        cycles(1'b1, 1'b0, 100);
        cycles(1'b0, 1'b0, 3);
`ifdef AUTOREPEAT_EN
        chk("hold_duty", 32'(DUTY), 32'd100);
`else
        chk("hold_duty", 32'(DUTY), 32'd60);
`endif
        cycles(1'b0, 1'b0, 8);

        // button held through reset release counts as one press
        BTN_UP = 1'b1;
        do_reset();
        cycles(1'b1, 1'b0, 12);
        chk("held_rst_duty", 32'(DUTY), 32'd60);
        cycles(1'b0, 1'b0, 8);

        // random sticky button levels with an occasional mid-run reset
        up_lvl = 1'b0;
        dn_lvl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) up_lvl = !up_lvl;
            if ($urandom_range(0, 5) == 0) dn_lvl = !dn_lvl;
            cyc(up_lvl, dn_lvl);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
